// File: rtl/blit_mem_pkg.sv
// Shared types and constants for the blitter memory responder.
package blit_mem_pkg;

  localparam int unsigned PHRASE_BYTES = 8;
  localparam int unsigned W_BYTE       = 1;
  localparam int unsigned W_WORD       = 2;
  localparam int unsigned W_LONG       = 4;
  localparam int unsigned W_PHRASE     = 8;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MADDR_W = 21;
  localparam int unsigned WIDTH_W = 4;
  localparam int unsigned OFF_W   = 3;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_AACK,
    ST_RDWAIT,
    ST_DACK
  } state_e;

  typedef struct packed {
    logic               read;
    logic [WIDTH_W-1:0] width;
    logic               justify;
    logic [ADDR_W-1:0]  addr;
  } req_t;

endpackage

// File: rtl/blit_lane_steer.sv
// Byte-lane steering between the blitter bus and a 64-bit phrase RAM.
module blit_lane_steer
  import blit_mem_pkg::*;
(
  input  logic [WIDTH_W-1:0]      width,
  input  logic                    justify,
  input  logic [OFF_W-1:0]        off,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W-1:0]       raw_rdata,
  output logic [PHRASE_BYTES-1:0] be_c,
  output logic [DATA_W-1:0]       wdata_c,
  output logic [DATA_W-1:0]       rdata_c,
  output logic                    overflow_c
);

  logic                    legal;
  logic [WIDTH_W-1:0]      nbytes;
  logic [15:0]             span;
  logic [15:0]             placed;
  logic [PHRASE_BYTES-1:0] lane_keep;
  logic [DATA_W-1:0]       keep_mask;
  logic [DATA_W-1:0]       rdata_shifted;

  always_comb begin
    legal  = (width >= WIDTH_W'(W_BYTE)) && (width <= WIDTH_W'(W_PHRASE));
    nbytes = legal ? width : WIDTH_W'(W_PHRASE);
    // 16-bit span so lanes pushed past byte 7 are visible as overflow
    span   = (16'(1) << nbytes) - 16'(1);
    placed = span << off;

    be_c       = placed[7:0];
    overflow_c = !legal || (|placed[15:8]);

    wdata_c       = justify ? (wdata << {off, 3'b000}) : wdata;
    rdata_shifted = justify ? (raw_rdata >> {off, 3'b000}) : raw_rdata;
    lane_keep     = justify ? span[7:0] : placed[7:0];

    keep_mask = '0;
    for (int i = 0; i < int'(PHRASE_BYTES); i++) begin
      keep_mask[8*i +: 8] = {8{lane_keep[i]}};
    end
    rdata_c = rdata_shifted & keep_mask;
  end

endmodule

// File: rtl/blit_mem_responder.sv
// Memory-side responder for blitter bus-master requests: wait states,
// address/data acks and a 1-cycle-latency phrase RAM port.
module blit_mem_responder
  import blit_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RD_EXTRA    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mreq,
  input  logic                    read,
  input  logic [WIDTH_W-1:0]      width,
  input  logic                    justify,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MADDR_W-1:0]      mem_addr,
  output logic [PHRASE_BYTES-1:0] mem_be,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  req_t                    req_q, req_d;
  logic [DATA_W-1:0]       cap_q, cap_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [MADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [PHRASE_BYTES-1:0] mem_be_q, mem_be_d;

  logic                    rd_first;
  logic [DATA_W-1:0]       raw_rdata;
  logic [PHRASE_BYTES-1:0] steer_be;
  logic [DATA_W-1:0]       steer_wdata;
  logic [DATA_W-1:0]       steer_rdata;
  logic                    steer_ovf;

  // Steering follows req_d so lanes are ready on the edge that enters AACK
  blit_lane_steer u_steer (
    .width      (req_d.width),
    .justify    (req_d.justify),
    .off        (req_d.addr[OFF_W-1:0]),
    .wdata      (wdata),
    .raw_rdata  (raw_rdata),
    .be_c       (steer_be),
    .wdata_c    (steer_wdata),
    .rdata_c    (steer_rdata),
    .overflow_c (steer_ovf)
  );

  always_comb begin
    rd_first  = (state_q == ST_RDWAIT) && (cnt_q == CNT_W'(RD_EXTRA));
    raw_rdata = rd_first ? mem_rdata : cap_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mreq) begin
          req_d.read    = read;
          req_d.width   = width;
          req_d.justify = justify;
          req_d.addr    = addr;
          if (WAIT_STATES == 0) begin
            state_d = ST_AACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!mreq) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_AACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_AACK: begin
        if (req_q.read) begin
          state_d = ST_RDWAIT;
          cnt_d   = CNT_W'(RD_EXTRA);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (rd_first) cap_d = mem_rdata;
        if (cnt_q == '0) begin
          state_d = ST_DACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it
    ack_d      = (state_d == ST_AACK) || (state_d == ST_DACK);
    mem_en_d   = (state_d == ST_AACK);
    mem_we_d   = mem_en_d && !req_d.read;
    mem_addr_d = mem_en_d ? req_d.addr[ADDR_W-1:OFF_W] : mem_addr_q;
    mem_be_d   = mem_en_d ? steer_be : '0;
    if (mem_en_d && steer_ovf) err_d = 1'b1;
    if (state_d == ST_DACK) rdata_d = steer_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
    end
  end

  // Write data must come from the bus during the ack cycle itself
  assign mem_wdata = steer_wdata;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;

endmodule

// File: doc/blit_mem_responder.md
Name: blit_mem_responder

Overview:
- Memory-side responder for the blitter's bus-master request interface (mreq/read/width/justify/address, ack).
- Samples a blitter request, inserts programmable wait states and returns ack.
- Writes: one address/data ack.
- Reads: an address ack, then a second ack carrying read data (the ack the blitter uses as read_ack).
- Drives a 1-cycle-latency synchronous 64-bit phrase RAM port, with byte-lane steering and byte enables.

Parameters:
WAIT_STATES, 1, cycles inserted between request sampling and address ack (0..15)
RD_EXTRA, 0, extra cycles between RAM data return and data ack (0..7)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
mreq  in  1  blitter memory request, held until address ack
read  in  1  1=read, 0=write; valid with mreq
width  in  4  transfer byte count: 1=byte, 2=word, 4=long, 8=phrase, others 1..8 allowed
justify  in  1  1=data right-justified on bus (lane shift by addr[2:0]); 0=natural lanes
addr  in  24  byte address
wdata  in  64  write data, valid in address-ack cycle
ack  out  1  one-cycle acknowledge pulse
rdata  out  64  read data, valid in data-ack cycle, held until next data ack
err  out  1  sticky: illegal width (0 or >8) or lane overflow seen
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable (with mem_en)
mem_addr  out  21  phrase address = addr[23:3]
mem_be  out  8  byte enables, lane i = bits 8i+7:8i
mem_wdata  out  64  steered write data
mem_rdata  in  64  RAM read data, valid the cycle after mem_en & !mem_we

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0.
  - ack=0, mem_en=0, mem_we=0, rdata=0, err=0.
  - A read in flight is dropped; no data ack is issued.
- States: IDLE, WAIT, AACK, RDWAIT, DACK.
- IDLE:
  - mreq=1 → latch read/width/justify/addr.
  - Go to WAIT with count=WAIT_STATES, or straight to AACK if WAIT_STATES=0.
- WAIT:
  - Decrement count; at 0 → AACK.
  - mreq=0 in WAIT aborts to IDLE: no ack, no RAM access.
- AACK (one cycle): ack=1, mem_en=1, mem_addr from latched addr.
  - Write: mem_we=1, mem_be and mem_wdata from live wdata; next state IDLE.
  - Read: mem_we=0; next state RDWAIT.
- RDWAIT: capture mem_rdata in the first cycle, wait RD_EXTRA cycles, then → DACK.
- DACK (one cycle): ack=1, rdata=steered captured data; next state IDLE.
- Latency: mreq first high at edge k → address ack in cycle k+1+WAIT_STATES. Read data ack = address-ack cycle + 2 + RD_EXTRA.
- No overlap rule:
  - A new request is never acked while read data is outstanding.
  - mreq seen in the data-ack cycle is sampled in IDLE the following cycle.
  - mreq still high the cycle after a write ack is a new request (back-to-back).
- Lane steering:
  - nbytes = width if 1..8, else 8 with err set.
  - off = addr[2:0].
  - mem_be = ((1<<nbytes)-1) << off, truncated to 8 bits. Truncation when off+nbytes>8 sets err.
  - justify=1: mem_wdata = wdata << 8*off; rdata = captured >> 8*off, upper non-enabled bytes zeroed.
  - justify=0: no shift; rdata = captured with non-enabled bytes zeroed.
- err is cleared only by reset.

Decomposition:
- Shared package blit_mem_pkg:
  - state enum;
  - width constants W_BYTE=1, W_WORD=2, W_LONG=4, W_PHRASE=8;
  - PHRASE_BYTES=8.
- Sub-module blit_lane_steer (combinational): width, justify, off, wdata, raw rdata → be, steered wdata, steered rdata, overflow.
- The FSM, counters and registers stay in the top module.

Test Plan:
- WAIT_STATES=1, write width=8 addr=0x001000 wdata=0x1122334455667788:
  - ack in cycle k+2;
  - mem_we=1, mem_addr=0x000200, mem_be=0xFF, data unchanged.
- Write width=2 justify=1 addr=0x000006 wdata=0xBEEF → mem_be=0xC0, mem_wdata=0xBEEF000000000000, err=0.
- Read width=4 justify=1 addr=0x000004, RAM returns 0xAABBCCDD11223344:
  - address ack, then data ack 2 cycles later;
  - rdata=0x00000000AABBCCDD.
- Overflow: write width=4 addr=0x000006 → mem_be=0xC0, err=1 and sticky. Separately, width=0 → treated as 8, err=1.
- Abort/reset:
  - mreq dropped during WAIT (WAIT_STATES=3) → no ack, mem_en never high.
  - reset_n low in RDWAIT → ack=0, rdata=0 immediately, no data ack after release.
- Back-to-back: two writes with mreq held high → two single-cycle acks separated by 1+WAIT_STATES cycles. Read then write → write ack only after the read data ack.
